// File: rtl/axis_decimator_pkg.sv
// axis_decimator_pkg: shared widths and helpers for the multi-channel decimator.
// Sizes the accumulator, clamps the requested decimation and locates lanes in a packed word.
package axis_decimator_pkg;

   // Width of the log2_dec request and of the active decimation register
   localparam int DEC_W = 4;

   // Accumulator width: one sample plus headroom for 2^max_log2 additions
   function automatic int ACC_W(input int sig_w, input int max_log2);
      return sig_w + max_log2;
   endfunction

   // Requests above the supported maximum fall back to the maximum
   function automatic logic [DEC_W-1:0] clamp_log2(input logic [DEC_W-1:0] req,
                                                   input int max_log2);
      if (int'(req) > max_log2) begin
         return DEC_W'(max_log2);
      end
      return req;
   endfunction

   // LSB position of lane k in a word with the given lane pitch
   function automatic int lane_lsb(input int k, input int pitch);
      return k * pitch;
   endfunction

endpackage

// File: rtl/axis_decimator_lane.sv
// axis_decimator_lane: one lane of the decimator. Sign-extends each sample, sums a block
// and presents the rescaled block result combinationally on the last sample.
// Optional macro AXIS_DECIMATOR_ROUND_EN adds half an LSB before the shift (round-half-up);
// without it the shift floors.
module axis_decimator_lane
   import axis_decimator_pkg::*;
#(
   parameter int SIG_WIDTH    = 14,
   parameter int MAX_LOG2_DEC = 8
)(
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [SIG_WIDTH-1:0] i_sample,
   input  logic                 i_valid,
   input  logic                 i_first,
   input  logic [DEC_W-1:0]     i_dec,
   output logic [SIG_WIDTH-1:0] o_result
);

   localparam int AW = ACC_W(SIG_WIDTH, MAX_LOG2_DEC);
   // One extra bit so the rounding constant can never wrap the full-scale sum
   localparam int TW = AW + 1;

   logic signed [AW-1:0] r_acc;
   logic signed [AW-1:0] w_ext;
   logic signed [AW-1:0] w_sum;
   logic signed [TW-1:0] w_round;
   logic signed [TW-1:0] w_total;
   logic signed [TW-1:0] w_shifted;
   logic                 w_unused_hi;

   assign w_ext = AW'($signed(i_sample));
   // A new block restarts from the sample itself, discarding the previous sum
   assign w_sum = i_first ? w_ext : (r_acc + w_ext);

`ifdef AXIS_DECIMATOR_ROUND_EN
   assign w_round = (i_dec == '0) ? '0 : (TW'(1) <<< (i_dec - DEC_W'(1)));
`else
   assign w_round = '0;
`endif

   assign w_total   = TW'(w_sum) + w_round;
   assign w_shifted = w_total >>> i_dec;
   // The mean of in-range samples always fits back into SIG_WIDTH bits
   assign o_result    = w_shifted[SIG_WIDTH-1:0];
   assign w_unused_hi = ^w_shifted[TW-1:SIG_WIDTH];

   // Running block sum, updated on every accepted sample
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_acc <= '0;
      end else if (i_valid) begin
         r_acc <= w_sum;
      end
   end

endmodule

// File: rtl/axis_multich_decimator.sv
// axis_multich_decimator: block-averaging decimator for NUM_CH packed ADC lanes with a
// backpressured AXI-stream result register and a sticky overrun flag.
// Optional macro AXIS_DECIMATOR_ROUND_EN (used inside axis_decimator_lane) enables rounding.
module axis_multich_decimator
   import axis_decimator_pkg::*;
#(
   parameter int NUM_CH       = 2,
   parameter int LANE_WIDTH   = 16,
   parameter int SIG_WIDTH    = 14,
   parameter int OUT_WIDTH    = 16,
   parameter int MAX_LOG2_DEC = 8
)(
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [NUM_CH*LANE_WIDTH-1:0] S_AXIS_SIGNAL_tdata,
   input  logic                        S_AXIS_SIGNAL_tvalid,
   input  logic [DEC_W-1:0]            log2_dec,
   input  logic                        overrun_clr,
   output logic [NUM_CH*OUT_WIDTH-1:0] M_AXIS_tdata,
   output logic                        M_AXIS_tvalid,
   input  logic                        M_AXIS_tready,
   output logic                        overrun
);

   localparam int CNT_W = (MAX_LOG2_DEC < 1) ? 1 : MAX_LOG2_DEC;

   logic                        r_init;
   logic [DEC_W-1:0]            r_dec_active;
   logic [CNT_W-1:0]            r_cnt;
   logic [NUM_CH*OUT_WIDTH-1:0] r_tdata;
   logic                        r_tvalid;
   logic                        r_overrun;

   logic [DEC_W-1:0]            w_dec_req;
   logic [DEC_W-1:0]            w_dec;
   logic [CNT_W-1:0]            w_cnt_max;
   logic                        w_first;
   logic                        w_last;
   logic                        w_result;
   logic                        w_load;
   logic [NUM_CH*OUT_WIDTH-1:0] w_out_word;
   logic [NUM_CH-1:0]           w_unused_pad;

   assign w_dec_req = clamp_log2(log2_dec, MAX_LOG2_DEC);
   // The first edge after reset is itself a block boundary, so the request applies directly
   assign w_dec     = r_init ? w_dec_req : r_dec_active;
   assign w_cnt_max = CNT_W'((32'd1 << w_dec) - 32'd1);
   assign w_first   = (r_cnt == '0);
   assign w_last    = (r_cnt == w_cnt_max);
   assign w_result  = S_AXIS_SIGNAL_tvalid && w_last;
   assign w_load    = w_result && (!r_tvalid || M_AXIS_tready);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
         logic [SIG_WIDTH-1:0] w_lane_res;

         axis_decimator_lane #(
            .SIG_WIDTH    (SIG_WIDTH),
            .MAX_LOG2_DEC (MAX_LOG2_DEC)
         ) u_lane (
            .aclk     (aclk),
            .aresetn  (aresetn),
            .i_sample (S_AXIS_SIGNAL_tdata[lane_lsb(gi, LANE_WIDTH) +: SIG_WIDTH]),
            .i_valid  (S_AXIS_SIGNAL_tvalid),
            .i_first  (w_first),
            .i_dec    (w_dec),
            .o_result (w_lane_res)
         );

         assign w_out_word[lane_lsb(gi, OUT_WIDTH) +: OUT_WIDTH] = OUT_WIDTH'($signed(w_lane_res));

         // Pad bits above the significant field of each input lane carry no information
         if (LANE_WIDTH > SIG_WIDTH) begin : g_pad
            assign w_unused_pad[gi] =
               ^S_AXIS_SIGNAL_tdata[lane_lsb(gi, LANE_WIDTH) + SIG_WIDTH +: LANE_WIDTH - SIG_WIDTH];
         end else begin : g_nopad
            assign w_unused_pad[gi] = 1'b0;
         end
      end
   endgenerate

   // Block sequencing: sample counter and boundary-only latch of the decimation factor
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_init       <= 1'b1;
         r_dec_active <= '0;
         r_cnt        <= '0;
      end else begin
         r_init <= 1'b0;
         if (r_init) begin
            r_dec_active <= w_dec_req;
         end
         if (S_AXIS_SIGNAL_tvalid) begin
            if (w_last) begin
               r_cnt        <= '0;
               r_dec_active <= w_dec_req;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Output register: load when free or draining, otherwise hold the pending word
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
      end else if (w_load) begin
         r_tdata  <= w_out_word;
         r_tvalid <= 1'b1;
      end else if (M_AXIS_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   // Sticky overrun: a result that finds the register blocked is lost; loss beats clear
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_overrun <= 1'b0;
      end else if (w_result && r_tvalid && !M_AXIS_tready) begin
         r_overrun <= 1'b1;
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
      end
   end

   assign M_AXIS_tdata  = r_tdata;
   assign M_AXIS_tvalid = r_tvalid;
   assign overrun       = r_overrun;

endmodule
